// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sequencer sharing one 19+19 -> 20 bit unsigned adder among NREQ
// requesters. One operation at a time: grant and latch operands (StIdle), capture the sum
// (StAdd), then hold the tagged result until it is acknowledged (StResp).
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   req           per-requester request, held until the matching gnt bit is seen
//   op_a, op_b    packed operands, slice i at [19*i +: 19]
//   gnt           one-hot grant pulse, issued in the cycle the operands are latched
//   add_a, add_b  registered inputs to the external shared adder
//   add_sum       combinational sum returned by the shared adder
//   res_valid     result valid, held until res_ack
//   res_id        requester index owning res_data
//   res_data      captured 20-bit sum
//   res_ack       result accepted (only meaningful in StResp)
//   busy          high whenever the sequencer is not idle
module adder_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*19-1:0] op_a,
   input  logic [NREQ*19-1:0] op_b,
   output logic [NREQ-1:0]    gnt,
   output logic [18:0]        add_a,
   output logic [18:0]        add_b,
   input  logic [19:0]        add_sum,
   output logic               res_valid,
   output logic [IDW-1:0]     res_id,
   output logic [19:0]        res_data,
   input  logic               res_ack,
   output logic               busy
);

   localparam int unsigned OpW = 19;

   typedef enum logic [1:0] {StIdle, StAdd, StResp} state_e;

   state_e          state_q, state_d;
   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [IDW-1:0]  cur_id_q, cur_id_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [OpW-1:0]  add_a_q, add_a_d;
   logic [OpW-1:0]  add_b_q, add_b_d;
   logic            res_valid_q, res_valid_d;
   logic [IDW-1:0]  res_id_q, res_id_d;
   logic [19:0]     res_data_q, res_data_d;

   // Winner search: the lowest set bit at or above ptr wins; failing that, the lowest set bit
   // overall, which gives the wrap from NREQ-1 back to 0.
   logic            found_hi, found_any;
   logic [IDW-1:0]  win_hi, win_lo, win_id;

   always_comb begin
      found_hi  = 1'b0;
      found_any = 1'b0;
      win_hi    = '0;
      win_lo    = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (req[i] && !found_any) begin
            found_any = 1'b1;
            win_lo    = IDW'(i);
         end
         if (req[i] && !found_hi && (IDW'(i) >= ptr_q)) begin
            found_hi = 1'b1;
            win_hi   = IDW'(i);
         end
      end
      win_id = found_hi ? win_hi : win_lo;
   end

   logic [OpW-1:0]  sel_a, sel_b;
   logic [NREQ-1:0] win_oh;

   always_comb begin
      sel_a  = '0;
      sel_b  = '0;
      win_oh = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (win_id == IDW'(i)) begin
            sel_a     = op_a[i*OpW +: OpW];
            sel_b     = op_b[i*OpW +: OpW];
            win_oh[i] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cur_id_d    = cur_id_q;
      gnt_d       = '0;  // grant is a single-cycle pulse
      add_a_d     = add_a_q;
      add_b_d     = add_b_q;
      res_valid_d = res_valid_q;
      res_id_d    = res_id_q;
      res_data_d  = res_data_q;
      unique case (state_q)
         StIdle: begin
            if (found_any) begin
               add_a_d  = sel_a;
               add_b_d  = sel_b;
               gnt_d    = win_oh;
               cur_id_d = win_id;
               state_d  = StAdd;
            end
         end
         StAdd: begin
            res_data_d  = add_sum;
            res_id_d    = cur_id_q;
            res_valid_d = 1'b1;
            state_d     = StResp;
         end
         StResp: begin
            // Priority only rotates once the owner has taken its result.
            if (res_ack) begin
               res_valid_d = 1'b0;
               ptr_d       = (cur_id_q == IDW'(NREQ - 1)) ? '0 : cur_id_q + IDW'(1);
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         ptr_q       <= '0;
         cur_id_q    <= '0;
         gnt_q       <= '0;
         add_a_q     <= '0;
         add_b_q     <= '0;
         res_valid_q <= 1'b0;
         res_id_q    <= '0;
         res_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cur_id_q    <= cur_id_d;
         gnt_q       <= gnt_d;
         add_a_q     <= add_a_d;
         add_b_q     <= add_b_d;
         res_valid_q <= res_valid_d;
         res_id_q    <= res_id_d;
         res_data_q  <= res_data_d;
      end
   end

   assign gnt       = gnt_q;
   assign add_a     = add_a_q;
   assign add_b     = add_b_q;
   assign res_valid = res_valid_q;
   assign res_id    = res_id_q;
   assign res_data  = res_data_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed self-checking bench for adder_arbiter (NREQ=4). The shared adder
// is modelled here as a plain continuous sum of the registered operands.
module tb_adder_arbiter;

   localparam int unsigned NREQ = 4;
   localparam int unsigned IDW  = 2;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [NREQ-1:0]    req = '0;
   logic [NREQ*19-1:0] op_a = '0;
   logic [NREQ*19-1:0] op_b = '0;
   logic [NREQ-1:0]    gnt;
   logic [18:0]        add_a, add_b;
   logic [19:0]        add_sum;
   logic               res_valid;
   logic [IDW-1:0]     res_id;
   logic [19:0]        res_data;
   logic               res_ack = 1'b0;
   logic               busy;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   assign add_sum = {1'b0, add_a} + {1'b0, add_b};

   adder_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .op_a      (op_a),
      .op_b      (op_b),
      .gnt       (gnt),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_sum   (add_sum),
      .res_valid (res_valid),
      .res_id    (res_id),
      .res_data  (res_data),
      .res_ack   (res_ack),
      .busy      (busy)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic set_op(input int i, input logic [18:0] a, input logic [18:0] b);
      op_a[i*19 +: 19] = a;
      op_b[i*19 +: 19] = b;
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_gnt"}, 32'(gnt), 32'h0);
      check_eq({tag, "_add_a"}, 32'(add_a), 32'h0);
      check_eq({tag, "_add_b"}, 32'(add_b), 32'h0);
      check_eq({tag, "_valid"}, 32'(res_valid), 32'h0);
      check_eq({tag, "_id"}, 32'(res_id), 32'h0);
      check_eq({tag, "_data"}, 32'(res_data), 32'h0);
      check_eq({tag, "_busy"}, 32'(busy), 32'h0);
   endtask

   // Step until a grant appears (bounded), then check it; t returns the grant cycle.
   task automatic expect_grant(input int id, input string tag, output int t);
      int n = 0;
      while (gnt == '0 && n < 8) begin
         step();
         n++;
      end
      check_eq({tag, "_seen"}, 32'(gnt != '0), 32'h1);
      check_eq(tag, 32'(gnt), 32'(1) << id);
      t = cyc;
   endtask

   task automatic expect_result(input int id, input logic [19:0] data, input string tag);
      step();
      check_eq({tag, "_valid"}, 32'(res_valid), 32'h1);
      check_eq({tag, "_id"}, 32'(res_id), 32'(id));
      check_eq({tag, "_data"}, 32'(res_data), 32'(data));
      check_eq({tag, "_gnt0"}, 32'(gnt), 32'h0);
   endtask

   task automatic ack_result(input string tag);
      res_ack = 1'b1;
      step();
      res_ack = 1'b0;
      check_eq({tag, "_ackvalid"}, 32'(res_valid), 32'h0);
      check_eq({tag, "_ackbusy"}, 32'(busy), 32'h0);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      int t, t0, t_prev;
      t_prev = 0;

      // Reset state
      repeat (2) step();
      rst = 1'b0;
      step();
      check_reset_vals("reset");

      // Single op with carry into bit 19
      set_op(0, 19'h7FFFF, 19'h7FFFF);
      req = 4'b0001;
      t0 = cyc;
      expect_grant(0, "t1_gnt", t);
      check_eq("t1_lat", 32'(t - t0), 32'd1);
      check_eq("t1_add_a", 32'(add_a), 32'h7FFFF);
      check_eq("t1_add_b", 32'(add_b), 32'h7FFFF);
      req = 4'b0000;
      expect_result(0, 20'hFFFFE, "t1_res");
      ack_result("t1");

      // Round-robin with all requesters held, operand i = (i, i+1)
      apply_reset();
      for (int i = 0; i < 4; i++) set_op(i, 19'(i), 19'(i + 1));
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         expect_grant(k % 4, "rr_gnt", t);
         if (k > 0) check_eq("rr_spacing", 32'(t - t_prev), 32'd3);
         t_prev = t;
         expect_result(k % 4, 20'(2 * (k % 4) + 1), "rr_res");
         if (k == 4) req = 4'b0000;
         ack_result("rr");
      end

      // Ack stall: id 2 holds the adder while req[1] waits (ptr is 1 here)
      req = 4'b0100;
      expect_grant(2, "stall_gnt", t);
      req = 4'b0010;
      expect_result(2, 20'h00005, "stall_res");
      for (int k = 0; k < 10; k++) begin
         step();
         check_eq("stall_valid", 32'(res_valid), 32'h1);
         check_eq("stall_id", 32'(res_id), 32'd2);
         check_eq("stall_data", 32'(res_data), 32'h5);
         check_eq("stall_busy", 32'(busy), 32'h1);
         check_eq("stall_nognt", 32'(gnt), 32'h0);
      end
      ack_result("stall");
      check_eq("stall_gnt_m1", 32'(gnt), 32'h0);
      t0 = cyc;
      expect_grant(1, "stall_gnt1", t);
      check_eq("stall_gnt1_lat", 32'(t - t0), 32'd1);
      req = 4'b0000;
      expect_result(1, 20'd3, "stall_res1");
      ack_result("stall1");

      // Wrap and priority; new req arrives together with the ack (ptr is 2 here)
      req = 4'b1000;
      expect_grant(3, "wrap_gnt3", t);
      req = 4'b0000;
      expect_result(3, 20'd7, "wrap_res3");
      req = 4'b1001;
      ack_result("wrap3");
      t0 = cyc;
      expect_grant(0, "wrap_gnt0", t);
      check_eq("wrap_gnt0_lat", 32'(t - t0), 32'd1);
      req = 4'b1000;
      expect_result(0, 20'd1, "wrap_res0");
      ack_result("wrap0");
      expect_grant(3, "wrap_gnt3b", t);
      req = 4'b0000;
      expect_result(3, 20'd7, "wrap_res3b");
      ack_result("wrap3b");

      // Reset during ADD, after ptr has moved to 3
      req = 4'b0100;
      expect_grant(2, "rst_pre_gnt", t);
      req = 4'b0000;
      expect_result(2, 20'd5, "rst_pre_res");
      ack_result("rst_pre");
      req = 4'b0001;
      expect_grant(0, "rst_add_gnt", t);
      req = 4'b0000;
      rst = 1'b1;
      #1;
      check_reset_vals("rst_add");
      step();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check_eq("rst_add_novalid", 32'(res_valid), 32'h0);
         check_eq("rst_add_nognt", 32'(gnt), 32'h0);
      end
      // ptr must be back at 0, so id 0 beats id 3
      req = 4'b1001;
      expect_grant(0, "rst_ptr_gnt", t);
      req = 4'b0000;
      step();
      check_eq("rst_resp_pre", 32'(res_valid), 32'h1);
      rst = 1'b1;
      #1;
      check_reset_vals("rst_resp");
      step();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check_eq("rst_resp_novalid", 32'(res_valid), 32'h0);
         check_eq("rst_resp_busy", 32'(busy), 32'h0);
      end

      // Idle with spurious acks: registered operands must hold (1, 2)
      req = 4'b0010;
      expect_grant(1, "idle_gnt", t);
      req = 4'b0000;
      expect_result(1, 20'd3, "idle_res");
      ack_result("idle");
      for (int k = 0; k < 20; k++) begin
         res_ack = ~res_ack;
         step();
         check_eq("idle_gnt0", 32'(gnt), 32'h0);
         check_eq("idle_valid", 32'(res_valid), 32'h0);
         check_eq("idle_busy", 32'(busy), 32'h0);
         check_eq("idle_add_a", 32'(add_a), 32'h1);
         check_eq("idle_add_b", 32'(add_b), 32'h2);
      end
      res_ack = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter and sequencer that shares one 19-bit + 19-bit → 20-bit unsigned adder among several neuron accumulation units in the network datapath. Each requester presents its operand pair with a request. The block grants one requester at a time, drives the shared adder's inputs from registers, and captures the 20-bit sum. It then returns the sum tagged with the requester index, holding it until the requester acknowledges it.

## Interface
- NREQ, 4: number of requesters (2..8).
- IDW, 2: width of the requester index, equal to ceil(log2(NREQ)).
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request; bit i is held high until gnt[i] is seen.
- op_a  in  NREQ*19  packed A operands; slice i is bits [19*i +: 19].
- op_b  in  NREQ*19  packed B operands, same packing as op_a.
- gnt  out  NREQ  one-hot grant, 1-cycle pulse; operands are latched on this cycle.
- add_a  out  19  registered A input to the shared adder.
- add_b  out  19  registered B input to the shared adder.
- add_sum  in  20  combinational sum returned by the shared adder (add_a + add_b).
- res_valid  out  1  result valid; held high until accepted.
- res_id  out  IDW  index of the requester that owns res_data.
- res_data  out  20  captured sum.
- res_ack  in  1  result accepted; only meaningful while res_valid=1.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- State machine has three states: IDLE, ADD, RESP.
- IDLE:
  - If req=0, stay in IDLE.
  - Otherwise pick the winner w: the first set req bit scanning upward from ptr, wrapping from NREQ-1 to 0.
  - Register add_a ← op_a[w] and add_b ← op_b[w].
  - Register gnt ← one-hot(w) and cur_id ← w.
  - Go to ADD.
- ADD:
  - gnt returns to 0.
  - Register res_data ← add_sum and res_id ← cur_id; set res_valid ← 1.
  - Go to RESP.
- RESP:
  - Hold res_valid, res_id, res_data and add_a/add_b stable.
  - On res_ack=1: res_valid ← 0, ptr ← (cur_id+1) mod NREQ, go to IDLE.
  - With res_ack=0, remain in RESP indefinitely.
- Arithmetic is unsigned: 20-bit sum of two 19-bit operands, so carry-out lands in bit 19 and there is no overflow or saturation.
- ptr advances only on ack. A requester whose result is unacknowledged blocks all others; this is by design.
- req bits are ignored outside IDLE.
  - A requester whose req is still high after its own result is acked competes again as normal, at lowest priority.
- res_ack outside RESP has no effect.
- NREQ values that are not a power of two: the wrap is at NREQ-1, and index values ≥ NREQ never appear.

## Timing
- Reset values:
  - gnt=0, add_a=0, add_b=0.
  - res_valid=0, res_id=0, res_data=0.
  - busy=0, state=IDLE, ptr=0, cur_id=0.
- Reset mid-operation aborts immediately. No gnt, res_valid or result survives reset; the requester must re-request.
- Let edge k be the rising edge that samples req in IDLE.
  - gnt is high during cycle k+1, i.e. the cycle after edge k.
  - res_valid is first high in cycle k+2.
  - Latency from req to result is 2 cycles.
- res_ack sampled high at edge m: res_valid=0 in cycle m+1, and the state is IDLE.
  - A new grant can be issued at edge m+1, so the earliest next gnt is cycle m+2.
  - Minimum issue interval is 3 cycles per operation.
- add_sum must settle within one clock period from the add_a/add_b register outputs; this is a single-cycle combinational path.
- Simultaneous res_ack and new req in RESP: the ack is processed first. The new req is arbitrated in the following IDLE cycle with the updated ptr.

## Test plan
- Single op with carry: req=4'b0001, op_a[0]=19'h7FFFF, op_b[0]=19'h7FFFF. Expect gnt=4'b0001 one cycle after req, then res_valid=1, res_id=0, res_data=20'hFFFFE one cycle later. Ack clears res_valid.
- Round-robin order: req=4'b1111 held, operand i = (i, i+1), ack immediate. Expect grants in order 0,1,2,3,0 and res_data=1,3,5,7 with matching res_id. Grant spacing is exactly 3 cycles.
- Ack stall: op 2+3 with res_ack low for 10 cycles. Expect res_valid, res_id and res_data=20'h00005 stable throughout, busy=1, and no gnt to the pending req[1]. gnt[1] comes 2 cycles after the ack.
- Wrap and priority: after serving id 3, req=4'b1001. Expect the next grant to id 0 (ptr wrapped to 0), then id 3.
- Reset mid-op: assert rst during ADD, then during RESP. Expect all outputs at reset values immediately, ptr=0, and no res_valid after release until a fresh req.
- Idle and spurious inputs: req=0 with res_ack toggling for 20 cycles. Expect gnt=0, res_valid=0, busy=0 and add_a/add_b unchanged.
